// File: rtl/midi_pkg.sv
// Shared constants and types for the MIDI voice allocator.
// Status nibbles, controller numbers, real-time threshold, parser enums.
package midi_pkg;

   localparam logic [3:0] ST_NOTE_OFF = 4'h8;
   localparam logic [3:0] ST_NOTE_ON  = 4'h9;
   localparam logic [3:0] ST_CTRL     = 4'hB;

   localparam logic [6:0] CC_ALL_SOUND_OFF = 7'd120;
   localparam logic [6:0] CC_ALL_NOTES_OFF = 7'd123;

   localparam logic [7:0] RT_THRESHOLD = 8'hF8;

   typedef enum logic [1:0] {
      PS_NONE,
      PS_DATA1,
      PS_DATA2
   } parse_state_e;

   typedef enum logic [1:0] {
      RS_NONE,
      RS_NOTE_OFF,
      RS_NOTE_ON,
      RS_CTRL
   } run_status_e;

endpackage

// File: rtl/midi_message_parser.sv
// MIDI byte parser with running status for one channel.
// Ports: clk, reset, byte_valid_i/byte_i in; note_on_o/note_off_o/all_off_o
// pulses with note_o/velocity_o, valid in the strobe cycle of the last byte.
module midi_message_parser
   import midi_pkg::*;
#(
   parameter logic [3:0] MIDI_CHANNEL = 4'd0
) (
   input  logic       clk,
   input  logic       reset,
   input  logic       byte_valid_i,
   input  logic [7:0] byte_i,
   output logic       note_on_o,
   output logic       note_off_o,
   output logic       all_off_o,
   output logic [6:0] note_o,
   output logic [6:0] velocity_o
);

   parse_state_e state_q, state_d;
   run_status_e  rs_q, rs_d;
   logic [6:0]   data1_q, data1_d;

   // Events are decoded combinationally so the voice registers in the
   // top capture them on the same edge as the completing byte.
   always_comb begin
      state_d    = state_q;
      rs_d       = rs_q;
      data1_d    = data1_q;
      note_on_o  = 1'b0;
      note_off_o = 1'b0;
      all_off_o  = 1'b0;
      note_o     = data1_q;
      velocity_o = byte_i[6:0];
      if (byte_valid_i && (byte_i < RT_THRESHOLD)) begin
         if (byte_i[7]) begin
            rs_d    = RS_NONE;
            state_d = PS_NONE;
            if (byte_i[3:0] == MIDI_CHANNEL) begin
               case (byte_i[7:4])
                  ST_NOTE_OFF: begin
                     rs_d    = RS_NOTE_OFF;
                     state_d = PS_DATA1;
                  end
                  ST_NOTE_ON: begin
                     rs_d    = RS_NOTE_ON;
                     state_d = PS_DATA1;
                  end
                  ST_CTRL: begin
                     rs_d    = RS_CTRL;
                     state_d = PS_DATA1;
                  end
                  default: ;
               endcase
            end
         end else begin
            case (state_q)
               PS_DATA1: begin
                  data1_d = byte_i[6:0];
                  state_d = PS_DATA2;
               end
               PS_DATA2: begin
                  state_d = PS_DATA1;
                  case (rs_q)
                     RS_NOTE_ON: begin
                        note_on_o  = (byte_i[6:0] != 7'd0);
                        note_off_o = (byte_i[6:0] == 7'd0);
                     end
                     RS_NOTE_OFF: note_off_o = 1'b1;
                     RS_CTRL: all_off_o =
                        (data1_q == CC_ALL_SOUND_OFF) ||
                        (data1_q == CC_ALL_NOTES_OFF);
                     default: ;
                  endcase
               end
               default: ;
            endcase
         end
      end
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state_q <= PS_NONE;
         rs_q    <= RS_NONE;
         data1_q <= 7'd0;
      end else begin
         state_q <= state_d;
         rs_q    <= rs_d;
         data1_q <= data1_d;
      end
   end

endmodule

// File: rtl/midi_voice_allocator.sv
// Polyphonic voice allocator driven by a MIDI byte stream.
// Ports: clk, reset, isByteAvailable/byteValue in; voiceActive, voiceNote,
// voiceVelocity (7 bits per voice packed) and voiceUpdate pulses out.
module midi_voice_allocator
   import midi_pkg::*;
#(
   parameter int         NUM_VOICES   = 4,
   parameter logic [3:0] MIDI_CHANNEL = 4'd0
) (
   input  logic                      clk,
   input  logic                      reset,
   input  logic                      isByteAvailable,
   input  logic [7:0]                byteValue,
   output logic [NUM_VOICES-1:0]     voiceActive,
   output logic [7*NUM_VOICES-1:0]   voiceNote,
   output logic [7*NUM_VOICES-1:0]   voiceVelocity,
   output logic [NUM_VOICES-1:0]     voiceUpdate
);

   localparam int RW = (NUM_VOICES > 1) ? $clog2(NUM_VOICES) : 1;

   logic       ev_on, ev_off, ev_all;
   logic [6:0] ev_note, ev_vel;

   midi_message_parser #(
      .MIDI_CHANNEL(MIDI_CHANNEL)
   ) u_parser (
      .clk         (clk),
      .reset       (reset),
      .byte_valid_i(isByteAvailable),
      .byte_i      (byteValue),
      .note_on_o   (ev_on),
      .note_off_o  (ev_off),
      .all_off_o   (ev_all),
      .note_o      (ev_note),
      .velocity_o  (ev_vel)
   );

   logic [NUM_VOICES-1:0] active_q, active_d;
   logic [NUM_VOICES-1:0] upd_q, upd_d;
   logic [6:0]            note_q [NUM_VOICES];
   logic [6:0]            note_d [NUM_VOICES];
   logic [6:0]            vel_q  [NUM_VOICES];
   logic [6:0]            vel_d  [NUM_VOICES];
   logic [RW-1:0]         rank_q [NUM_VOICES];
   logic [RW-1:0]         rank_d [NUM_VOICES];

   logic          hit, free;
   logic [RW-1:0] hit_idx, free_idx, old_idx, sel;

   always_comb begin
      active_d = active_q;
      note_d   = note_q;
      vel_d    = vel_q;
      rank_d   = rank_q;
      upd_d    = '0;
      hit      = 1'b0;
      free     = 1'b0;
      hit_idx  = '0;
      free_idx = '0;
      old_idx  = '0;
      // Victim priority: same note already sounding, then lowest free
      // slot, then the voice holding the oldest rank.
      for (int i = 0; i < NUM_VOICES; i++) begin
         if (active_q[i] && (note_q[i] == ev_note) && !hit) begin
            hit     = 1'b1;
            hit_idx = RW'(i);
         end
         if (!active_q[i] && !free) begin
            free     = 1'b1;
            free_idx = RW'(i);
         end
         if (rank_q[i] == RW'(NUM_VOICES - 1))
            old_idx = RW'(i);
      end
      sel = hit ? hit_idx : (free ? free_idx : old_idx);
      if (ev_on) begin
         for (int i = 0; i < NUM_VOICES; i++) begin
            if (rank_q[i] < rank_q[sel])
               rank_d[i] = rank_q[i] + RW'(1);
         end
         rank_d[sel]   = '0;
         active_d[sel] = 1'b1;
         note_d[sel]   = ev_note;
         vel_d[sel]    = ev_vel;
      end else if (ev_off) begin
         for (int i = 0; i < NUM_VOICES; i++) begin
            if (note_q[i] == ev_note)
               active_d[i] = 1'b0;
         end
      end else if (ev_all) begin
         active_d = '0;
      end
      for (int i = 0; i < NUM_VOICES; i++) begin
         upd_d[i] = (active_d[i] != active_q[i]) ||
                    (note_d[i] != note_q[i]) ||
                    (vel_d[i] != vel_q[i]);
      end
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         active_q <= '0;
         upd_q    <= '0;
         for (int i = 0; i < NUM_VOICES; i++) begin
            note_q[i] <= 7'd0;
            vel_q[i]  <= 7'd0;
            rank_q[i] <= RW'(i);
         end
      end else begin
         active_q <= active_d;
         upd_q    <= upd_d;
         note_q   <= note_d;
         vel_q    <= vel_d;
         rank_q   <= rank_d;
      end
   end

   always_comb begin
      voiceNote     = '0;
      voiceVelocity = '0;
      for (int i = 0; i < NUM_VOICES; i++) begin
         voiceNote[7*i +: 7]     = note_q[i];
         voiceVelocity[7*i +: 7] = vel_q[i];
      end
   end

   assign voiceActive = active_q;
   assign voiceUpdate = upd_q;

endmodule
